// File: rtl/cp0_unit.sv
// cp0_unit: MIPS coprocessor 0 (SR, Cause, EPC, PRId) with interrupt/exception arbitration.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_unit #(
  parameter int          NUM_HWINT    = 6,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID         = 32'h4D49_5053
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           raddr,
  output logic [31:0]          rdata,
  input  logic [4:0]           waddr,
  input  logic [31:0]          wdata,
  input  logic                 we,
  input  logic [31:0]          vpc,
  input  logic                 bd_in,
  input  logic [4:0]           exc_code_in,
  input  logic                 eret,
  input  logic [NUM_HWINT-1:0] hwint,
  output logic                 req,
  output logic [31:0]          epc_out,
  output logic [31:0]          handler_pc
);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_SR      = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_PRID    = 5'd15;

  logic [5:0]  r_im;
  logic [5:0]  r_ip;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [4:0]  r_exc;
  logic [31:0] r_epc;

  logic [5:0]  w_hw;
  logic [5:0]  w_ip;
  logic        w_ti;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_int;
  logic        w_exc;
  logic        w_req;
  logic        w_mtc0;

  // Lines beyond NUM_HWINT are tied off so IP reads 0 there.
  for (genvar i = 0; i < 6; i++) begin : g_hw
    if (i < NUM_HWINT) begin : g_on
      assign w_hw[i] = hwint[i];
    end else begin : g_off
      assign w_hw[i] = 1'b0;
    end
  end

  assign w_ip   = r_ip | {w_ti, 5'b0};
  assign w_int  = (|(w_ip & r_im)) & r_ie & ~r_exl;
  assign w_exc  = (exc_code_in != 5'd0) & ~r_exl;
  assign w_req  = ~reset & (w_int | w_exc);
  assign w_mtc0 = we & ~w_req;

  assign req        = w_req;
  assign handler_pc = HANDLER_ADDR;
  assign epc_out    = reset ? 32'd0 :
                      (w_mtc0 && waddr == A_EPC) ? wdata : r_epc;

  // Status/Cause/EPC update: reset > trap entry > eret > mtc0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_im  <= '0;
      r_ip  <= '0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_bd  <= 1'b0;
      r_exc <= '0;
      r_epc <= '0;
    end else begin
      r_ip <= w_hw;
      if (w_req) begin
        r_exl <= 1'b1;
        r_exc <= w_int ? 5'd0 : exc_code_in;
        r_bd  <= bd_in;
        r_epc <= bd_in ? vpc - 32'd4 : vpc;
      end else begin
        if (we && waddr == A_SR) begin
          r_im  <= wdata[15:10];
          r_exl <= wdata[1];
          r_ie  <= wdata[0];
        end
        if (we && waddr == A_EPC)
          r_epc <= wdata;
        if (eret)
          r_exl <= 1'b0;
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;

  // Free-running Count; TI latches on match, cleared by a Compare write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_compare <= 32'hFFFF_FFFF;
      r_ti      <= 1'b0;
    end else begin
      if (w_mtc0 && waddr == A_COUNT)
        r_count <= wdata;
      else
        r_count <= r_count + 32'd1;
      if (w_mtc0 && waddr == A_COMPARE) begin
        r_compare <= wdata;
        r_ti      <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign w_ti      = r_ti;
  assign w_count   = r_count;
  assign w_compare = r_compare;
`else
  logic w_unused;
  assign w_unused  = ^wdata;
  assign w_ti      = 1'b0;
  assign w_count   = 32'd0;
  assign w_compare = 32'd0;
`endif

  // mfc0 read mux; unimplemented registers read 0.
  always_comb begin
    rdata = 32'd0;
    case (raddr)
      A_COUNT:   rdata = w_count;
      A_COMPARE: rdata = w_compare;
      A_SR:      rdata = {16'd0, r_im, 8'd0, r_exl, r_ie};
      A_CAUSE:   rdata = {r_bd, w_ti, 14'd0, w_ip, 3'd0, r_exc, 2'd0};
      A_EPC:     rdata = r_epc;
      A_PRID:    rdata = PRID;
      default:   rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed test-plan steps plus random traffic against a CP0 reference model.
// Follows CP0_TIMER_EN the same way the design does.
module tb_cp0_unit;

  localparam int NH = 6;
  localparam logic [31:0] PRID_V = 32'h4D49_5053;
  localparam logic [31:0] HV     = 32'h0000_4180;
`ifdef CP0_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    raddr;
  logic [31:0]   rdata;
  logic [4:0]    waddr;
  logic [31:0]   wdata;
  logic          we;
  logic [31:0]   vpc;
  logic          bd_in;
  logic [4:0]    exc_code_in;
  logic          eret;
  logic [NH-1:0] hwint;
  logic          req;
  logic [31:0]   epc_out;
  logic [31:0]   handler_pc;

  always #5 clk = ~clk;

  cp0_unit #(.NUM_HWINT(NH)) dut (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata),
    .waddr(waddr), .wdata(wdata), .we(we), .vpc(vpc),
    .bd_in(bd_in), .exc_code_in(exc_code_in), .eret(eret),
    .hwint(hwint), .req(req), .epc_out(epc_out),
    .handler_pc(handler_pc)
  );

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  logic [5:0]  m_im, m_ip;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_cnt, m_cmp;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [5:0] m_ipv();
    return m_ip | {(TMR & m_ti), 5'b0};
  endfunction

  function automatic logic m_int();
    return ((m_ipv() & m_im) != 6'd0) && m_ie && !m_exl;
  endfunction

  function automatic logic m_reqf();
    return m_int() || (exc_code_in != 5'd0 && !m_exl);
  endfunction

  function automatic logic [31:0] m_epcout();
    if (we && waddr == 5'd14 && !m_reqf()) return wdata;
    return m_epc;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return TMR ? m_cnt : 32'd0;
      5'd11:   return TMR ? m_cmp : 32'd0;
      5'd12:   return {16'd0, m_im, 8'd0, m_exl, m_ie};
      5'd13:   return {m_bd, (TMR & m_ti), 14'd0, m_ipv(), 3'd0, m_code, 2'd0};
      5'd14:   return m_epc;
      5'd15:   return PRID_V;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_im = '0; m_ip = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0;
    m_code = '0; m_epc = '0; m_cnt = '0; m_cmp = 32'hFFFF_FFFF;
  endtask

  task automatic m_edge();
    logic r, i, mw, nti;
    logic [31:0] ncnt;
    r  = m_reqf();
    i  = m_int();
    mw = we && !r;
    ncnt = (mw && waddr == 5'd9) ? wdata : m_cnt + 32'd1;
    if (mw && waddr == 5'd11) nti = 1'b0;
    else if (m_cnt == m_cmp)  nti = 1'b1;
    else                      nti = m_ti;
    if (mw && waddr == 5'd11) m_cmp = wdata;
    m_cnt = ncnt;
    m_ti  = nti;
    if (r) begin
      m_exl  = 1'b1;
      m_code = i ? 5'd0 : exc_code_in;
      m_bd   = bd_in;
      m_epc  = bd_in ? vpc - 32'd4 : vpc;
    end else begin
      if (mw && waddr == 5'd12) begin
        m_im  = wdata[15:10];
        m_exl = wdata[1];
        m_ie  = wdata[0];
      end
      if (mw && waddr == 5'd14) m_epc = wdata;
      if (eret) m_exl = 1'b0;
    end
    m_ip = hwint;
  endtask

  // one clock: check combinational outputs, take the edge, advance model
  task automatic cyc();
    #1;
    if (reset) begin
      check("req_rst", 32'(req), 32'd0);
      check("epc_rst", epc_out, 32'd0);
    end else begin
      check("req", 32'(req), 32'(m_reqf()));
      check("epc_out", epc_out, m_epcout());
      check("rdata", rdata, m_read(raddr));
    end
    @(posedge clk);
    if (reset) m_reset();
    else m_edge();
    #1;
  endtask

  task automatic peek(input logic [4:0] a, output logic [31:0] v);
    raddr = a;
    #1;
    v = rdata;
  endtask

  task automatic idle();
    we = 0; waddr = '0; wdata = '0; eret = 0; exc_code_in = '0;
    bd_in = 0; vpc = '0; hwint = '0; raddr = '0;
  endtask

  initial begin
    logic [31:0] v;
    logic        found;
    logic [4:0]  regs [8];
    regs[0] = 5'd9;  regs[1] = 5'd11; regs[2] = 5'd12; regs[3] = 5'd13;
    regs[4] = 5'd14; regs[5] = 5'd15; regs[6] = 5'd0;  regs[7] = 5'd12;

    reset = 1'b1;
    idle();
    m_reset();
    @(posedge clk);
    #1;
    cyc();
    cyc();
    reset = 1'b0;

    // reset state
    peek(5'd12, v); check("sr_rst", v, 32'd0);
    peek(5'd13, v); check("cause_rst", v, 32'd0);
    peek(5'd14, v); check("epc_reg_rst", v, 32'd0);
    check("handler_pc", handler_pc, HV);
    peek(5'd15, v); check("prid", v, PRID_V);
    cyc();

    // interrupt entry
    we = 1; waddr = 5'd12; wdata = 32'h0000_0401;
    hwint = 6'd1; vpc = 32'h3010;
    cyc();
    we = 0;
    #1 check("int_req", 32'(req), 32'd1);
    cyc();
    peek(5'd12, v); check("int_exl", 32'(v[1]), 32'd1);
    peek(5'd13, v); check("int_code", 32'(v[6:2]), 32'd0);
    peek(5'd14, v); check("int_epc", v, 32'h3010);
    eret = 1; hwint = '0;
    cyc();
    eret = 0;

    // delay-slot exception, then blocked while EXL=1
    exc_code_in = 5'd12; bd_in = 1; vpc = 32'h3024;
    #1 check("exc_req", 32'(req), 32'd1);
    cyc();
    peek(5'd14, v); check("exc_epc", v, 32'h3020);
    peek(5'd13, v); check("exc_cause", v, 32'h8000_0030);
    exc_code_in = 5'd4; bd_in = 0;
    #1 check("exc_blocked", 32'(req), 32'd0);
    cyc();
    exc_code_in = '0; eret = 1;
    cyc();
    eret = 0;

    // interrupt beats exception; mtc0 EPC dropped
    hwint = 6'd1; vpc = 32'h0;
    cyc();
    exc_code_in = 5'd10; we = 1; waddr = 5'd14;
    wdata = 32'hDEAD_0000; vpc = 32'h3040;
    #1 check("prio_req", 32'(req), 32'd1);
    check("prio_nobypass", epc_out, 32'h3020);
    cyc();
    we = 0; exc_code_in = '0;
    peek(5'd13, v); check("prio_code", 32'(v[6:2]), 32'd0);
    peek(5'd14, v); check("prio_epc", v, 32'h3040);
    hwint = '0; eret = 1;
    cyc();
    eret = 0;

    // eret with same-cycle EPC write and bypass
    exc_code_in = 5'd8; vpc = 32'h3050;
    cyc();
    exc_code_in = '0; eret = 1; we = 1; waddr = 5'd14; wdata = 32'h3100;
    #1 check("bypass", epc_out, 32'h3100);
    cyc();
    we = 0; eret = 0;
    peek(5'd12, v); check("eret_exl", 32'(v[1]), 32'd0);
    peek(5'd14, v); check("eret_epc", v, 32'h3100);

    // masking: IE=0, then IM=0
    we = 1; waddr = 5'd12; wdata = 32'h0000_FC00; hwint = 6'h3F;
    cyc();
    we = 0;
    cyc();
    #1 check("mask_ie", 32'(req), 32'd0);
    peek(5'd13, v); check("mask_ip", 32'(v[15:10]), 32'h3F);
    we = 1; wdata = 32'h0000_0001;
    cyc();
    we = 0;
    #1 check("mask_im", 32'(req), 32'd0);
    cyc();
    hwint = '0;
    cyc();

`ifdef CP0_TIMER_EN
    // timer: Compare=5, Count=0, enable IM[5]
    we = 1; waddr = 5'd11; wdata = 32'd5;
    cyc();
    waddr = 5'd9; wdata = 32'd0;
    cyc();
    waddr = 5'd12; wdata = 32'h0000_8001;
    cyc();
    we = 0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      peek(5'd13, v);
      if (v[30]) found = 1'b1;
      else cyc();
    end
    check("ti_seen", 32'(found), 32'd1);
    check("ti_req", 32'(req), 32'd1);
    cyc();
    we = 1; waddr = 5'd11; wdata = 32'h100; eret = 1;
    cyc();
    we = 0; eret = 0;
    peek(5'd13, v); check("ti_clear", 32'(v[30]), 32'd0);
    cyc();
`else
    found = 1'b0;
`endif

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset       = (n == 200);
      we          = ($urandom % 4) == 0;
      waddr       = regs[$urandom % 8];
      wdata       = $urandom;
      eret        = ($urandom % 5) == 0;
      exc_code_in = (($urandom % 6) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      bd_in       = 1'($urandom);
      vpc         = $urandom & 32'hFFFF_FFFC;
      hwint       = (($urandom % 8) == 0) ? NH'($urandom) : '0;
      raddr       = (($urandom % 4) == 0) ? 5'($urandom) : regs[$urandom % 8];
      cyc();
    end
    reset = 1'b0;
    idle();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
